// File: rtl/series_dispatch_pkg.sv
// series_dispatch_pkg: shared widths, job bundle and FSM states
// for the series job dispatcher and its FIFO.
package series_dispatch_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 8;
  localparam int R_W = 10;

  localparam logic [R_W-1:0] RESULT_TIMEOUT = 10'h3FF;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } job_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    HOLD
  } state_t;

endpackage

// File: rtl/series_job_dispatcher_if.sv
// series_job_dispatcher_if: job input channel (in_*) and result
// output channel (out_*); slave = dispatcher, master = environment.
interface series_job_dispatcher_if;
  import series_dispatch_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [X_W-1:0] in_x;
  logic [Y_W-1:0] in_y;
  logic           out_valid;
  logic           out_ready;
  logic [R_W-1:0] out_result;
  logic           out_err;

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_result, out_err
  );

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_result, out_err
  );

endinterface

// File: rtl/series_job_dispatcher_fifo.sv
// job_fifo: DEPTH-entry job queue; ports clk/rst, push/wdata,
// pop, head (register read at rd_ptr), full/empty/level.
module job_fifo
  import series_dispatch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = job_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       wdata,
  input  logic                   pop,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  T mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/series_job_dispatcher.sv
// series_job_dispatcher: queues (x,y) jobs, runs one at a time on
// the engine (eng_start/eng_x/eng_y -> eng_done/eng_result) and
// offers each result on bus.out_*; level = queue occupancy.
// Option SERIES_DISPATCH_TIMEOUT_EN aborts a run after TIMEOUT
// WAIT cycles with result 3FF and out_err set.
module series_job_dispatcher
  import series_dispatch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  series_job_dispatcher_if.slave bus,
  output logic                   eng_start,
  output logic [X_W-1:0]         eng_x,
  output logic [Y_W-1:0]         eng_y,
  input  logic                   eng_done,
  input  logic [R_W-1:0]         eng_result,
  output logic [$clog2(DEPTH):0] level
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("series_job_dispatcher: bad DEPTH/TIMEOUT");
  end

  state_t state;
  state_t next;

  job_t in_job;
  job_t head;
  logic full;
  logic empty;
  logic pop;
  logic capture;
  logic expire;
  logic tmo_hit;

  assign in_job.x     = bus.in_x;
  assign in_job.y     = bus.in_y;
  assign bus.in_ready = !full;

  job_fifo #(
    .DEPTH (DEPTH),
    .T     (job_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .wdata (in_job),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

`ifdef SERIES_DISPATCH_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst)                 wait_cnt <= '0;
    else if (state == LAUNCH) wait_cnt <= '0;
    else if (state == WAIT)   wait_cnt <= wait_cnt + 8'd1;
  end

  // Fires in the WAIT cycle that brings the count to TIMEOUT.
  assign tmo_hit = (state == WAIT) &&
                   (wait_cnt == 8'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next    = state;
    pop     = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) next = LAUNCH;
      end
      LAUNCH: begin
        pop  = 1'b1;
        next = WAIT;
      end
      WAIT: begin
        // A done arriving with the timeout still counts as normal.
        if (eng_done) begin
          capture = 1'b1;
          next    = HOLD;
        end else if (tmo_hit) begin
          expire = 1'b1;
          next   = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // eng_start is registered so it lines up with the new eng_x/eng_y.
  always_ff @(posedge clk) begin
    if (rst) begin
      eng_start      <= 1'b0;
      eng_x          <= '0;
      eng_y          <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_err    <= 1'b0;
    end else begin
      eng_start <= pop;
      if (pop) begin
        eng_x <= head.x;
        eng_y <= head.y;
      end
      if (capture) begin
        bus.out_result <= eng_result;
        bus.out_err    <= 1'b0;
        bus.out_valid  <= 1'b1;
      end else if (expire) begin
        bus.out_result <= RESULT_TIMEOUT;
        bus.out_err    <= 1'b1;
        bus.out_valid  <= 1'b1;
      end else if (state == HOLD && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule
